sopc_data_mem: RTL
==================

# sopc_data_mem

Parametrised data-memory slave for the SOPC top level; it replaces the fixed single-cycle data RAM behind the CPU's load/store port. It adds a valid/ready request handshake, a programmable wait-state counter, true per-byte-lane select sized from the data width, and a registered response. Optional address-range checking flags accesses outside the mapped window.

## Interface
- DATA_W, 32, data width in bits; multiple of 8
- ADDR_W, 32, byte-address width
- DEPTH, 1024, number of DATA_W words; power of two
- WAIT_CYCLES, 1, extra wait cycles per access; range 0..15
- BASE_ADDR, 32'h0000_0000, byte address of word 0
- clk  in  1  system clock; all logic on the rising edge
- rst  in  1  reset; asynchronous assert, active-low (0 = reset)
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_sel  in  DATA_W/8  byte-lane enables; bit i covers data bits [8i+7:8i]
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  read data; valid only with rsp_valid
- rsp_err  out  1  address error; valid only with rsp_valid

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - Handshake on the edge where req_valid && req_ready; latch we/addr/sel/wdata.
  - Go to WAIT with counter=WAIT_CYCLES, or to RESP when WAIT_CYCLES=0.
- WAIT:
  - req_ready=0.
  - Counter decrements each cycle; go to RESP on the edge where counter==1.
- RESP:
  - req_ready=0.
  - rsp_valid=1 for exactly one cycle; return to IDLE next edge.
  - No response backpressure.
- Word index:
  - index = (addr - BASE_ADDR) >> log2(DATA_W/8); low address bits ignored.
  - Index truncated to log2(DEPTH) bits, so addresses wrap modulo DEPTH.
- Write:
  - Memory update on the edge entering RESP.
  - Only lanes with sel=1 change; sel=0 gives a normal response with no change.
  - rsp_rdata=0 on writes.
- Read:
  - rsp_rdata holds the word, with unselected lanes forced to 0.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE; req_ready=1 once rst deasserts.
- Latency: rsp_valid is high in cycle N+WAIT_CYCLES+1 when the handshake occurs at edge N.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- req_ready is a combinational decode of the state only; it never depends on req_valid.
- Reset mid-transaction:
  - Any in-flight access is dropped: no response, no memory write.
  - Memory words written earlier keep their values.
- req_valid while req_ready=0: ignored; the master must hold the request.
- Request inputs are sampled only at the handshake edge.

## Configuration
- Macro SOPC_DATA_MEM_ADDR_CHECK_EN.
- Defined:
  - An access with addr < BASE_ADDR, or addr >= BASE_ADDR + DEPTH*DATA_W/8, sets rsp_err=1 with its response.
  - The write is suppressed and rsp_rdata=0.
  - Latency is unchanged.
- Undefined:
  - No range check; addresses wrap as above.
  - rsp_err is tied to 0.

## Structure
- Package sopc_mem_pkg holds:
  - state enum {IDLE, WAIT, RESP}
  - WAIT_CNT_W=4
  - function lanes(DATA_W)=DATA_W/8
  - function clog2 for index width
- Sub-module sopc_mem_array:
  - DEPTH x DATA_W storage with byte-lane write enables.
  - Single synchronous write port; combinational read.
- Top level holds the FSM, wait counter, request latches, address decode/check and response registers.

## Test plan
- Reset then idle: after rst rises, req_ready=1, rsp_valid=0, rsp_rdata=0, and they stay so with no request.
- Full write/read, WAIT_CYCLES=1:
  - Write 0xDEADBEEF to 0x10 with sel=4'b1111, then read 0x10 with sel=4'b1111.
  - rsp_valid appears 2 cycles after each handshake; read returns 0xDEADBEEF.
- Byte lanes:
  - Write 0x11223344 to 0x20 (sel=1111), write 0xAA000000 (sel=1000), then read with sel=1111 → 0xAA223344.
  - Read with sel=0011 → 0x00003344.
- Wait states, WAIT_CYCLES=0 and 15:
  - rsp_valid at handshake+1 and handshake+16 respectively.
  - req_ready low every cycle in between; requests held during that time are not accepted early.
- Wrap and error, DEPTH=16, BASE_ADDR=0:
  - Write 0x5 to 0x40, then read 0x00.
  - Without the macro: returns 0x5, rsp_err=0.
  - With SOPC_DATA_MEM_ADDR_CHECK_EN: rsp_err=1 on the write, and the read returns the prior value.
- Reset mid-access:
  - Assert rst during WAIT of a write of 0x12345678 to 0x30.
  - No rsp_valid pulse; a later read of 0x30 returns the pre-write value.

Source files
------------

// File: rtl/sopc_mem_pkg.sv
// sopc_mem_pkg: shared types and helpers for the SOPC data-memory slave.
package sopc_mem_pkg;

  // Access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Wait-state counter width; covers WAIT_CYCLES up to 15
  localparam int WAIT_CNT_W = 4;

  // Number of byte lanes in a data word
  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  // Ceiling log2; returns 0 for an argument of 1
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sopc_mem_array.sv
// sopc_mem_array: DEPTH x DATA_W storage, one synchronous byte-lane write
// port and one combinational read port. Contents are never reset.
module sopc_mem_array
  import sopc_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int IDX_W  = 10
) (
  input  logic                    clk,
  input  logic                    wr_en,
  input  logic [IDX_W-1:0]        wr_idx,
  input  logic [lanes(DATA_W)-1:0] wr_be,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [IDX_W-1:0]        rd_idx,
  output logic [DATA_W-1:0]       rd_data
);

  localparam int LANES = lanes(DATA_W);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-lane write: only enabled lanes of the addressed word change
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sopc_data_mem.sv
// sopc_data_mem: data-memory slave with valid/ready request handshake,
// programmable wait states, byte-lane selects and a registered one-cycle
// response. Optional range check enabled by SOPC_DATA_MEM_ADDR_CHECK_EN.
module sopc_data_mem
  import sopc_mem_pkg::*;
#(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter int              DEPTH       = 1024,
  parameter int              WAIT_CYCLES = 1,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [ADDR_W-1:0]        req_addr,
  input  logic [lanes(DATA_W)-1:0] req_sel,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err
);

  localparam int LANES   = lanes(DATA_W);
  localparam int LANE_SH = clog2(LANES);
  localparam int IDX_W   = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    we_q, we_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LANES-1:0]        sel_q, sel_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_err_q, rsp_err_d;

  logic                    hs;
  logic                    enter_resp;
  logic                    acc_we;
  logic [ADDR_W-1:0]       acc_addr;
  logic [LANES-1:0]        acc_sel;
  logic [DATA_W-1:0]       acc_wdata;
  logic [ADDR_W-1:0]       acc_offset;
  logic [IDX_W-1:0]        acc_idx;
  logic [DATA_W-1:0]       lane_mask;
  logic [DATA_W-1:0]       rd_word;
  logic                    addr_err;
  logic                    wr_en;

  // Ready is a pure state decode so masters never see a valid->ready loop
  assign req_ready = (state_q == IDLE);
  assign hs        = req_valid && req_ready;

  // With zero wait states the access completes on the handshake edge itself,
  // so the live request is used in IDLE and the latched copy otherwise.
  assign acc_we    = (state_q == IDLE) ? req_we    : we_q;
  assign acc_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign acc_sel   = (state_q == IDLE) ? req_sel   : sel_q;
  assign acc_wdata = (state_q == IDLE) ? req_wdata : wdata_q;

  // Word index relative to the window base; wraps modulo DEPTH
  assign acc_offset = acc_addr - BASE_ADDR;
  assign acc_idx    = IDX_W'(acc_offset >> LANE_SH);

  // Expand per-lane selects to a bit mask for read data
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane_mask
      assign lane_mask[8*gi +: 8] = {8{acc_sel[gi]}};
    end
  endgenerate

`ifdef SOPC_DATA_MEM_ADDR_CHECK_EN
  // One extra bit keeps the window end from overflowing near the top of the map
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = WIN_LO + (ADDR_W+1)'(DEPTH * LANES);
  assign addr_err = ({1'b0, acc_addr} < WIN_LO) || ({1'b0, acc_addr} >= WIN_HI);
`else
  assign addr_err = 1'b0;
`endif

  // Write commits on the edge entering RESP; gated by reset so an access
  // caught by reset never reaches the array.
  assign wr_en = rst && enter_resp && acc_we && !addr_err;

  sopc_mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_idx  (acc_idx),
    .wr_be   (acc_sel),
    .wr_data (acc_wdata),
    .rd_idx  (acc_idx),
    .rd_data (rd_word)
  );

  // Next-state, wait counter and request latch logic
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          we_d    = req_we;
          addr_d  = req_addr;
          sel_d   = req_sel;
          wdata_d = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == CNT_ONE) begin
          state_d    = RESP;
          enter_resp = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Response payload: read data masked to selected lanes, zero otherwise
  always_comb begin
    rsp_valid_d = enter_resp;
    rsp_err_d   = enter_resp && addr_err;
    rsp_rdata_d = '0;
    if (enter_resp && !acc_we && !addr_err) begin
      rsp_rdata_d = rd_word & lane_mask;
    end
  end

  // State, latches and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      sel_q       <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      sel_q       <= sel_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
